// File: rtl/req_encoder_pkg.sv
// Shared constants, state encoding and popcount helper for the request encoder.
package req_encoder_pkg;

  localparam int unsigned REQ_W  = 8;
  localparam int unsigned CODE_W = 3;
  localparam int unsigned CNT_W  = 4;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  function automatic logic [CNT_W-1:0] popcount(input logic [REQ_W-1:0] v);
    logic [CNT_W-1:0] sum;
    sum = '0;
    for (int i = 0; i < int'(REQ_W); i++) begin
      sum = sum + CNT_W'(v[i]);
    end
    return sum;
  endfunction

endpackage

// File: rtl/req_encoder_prio_pick8.sv
// Combinational priority picker: index of the winning set bit and an any-set flag.
module prio_pick8
  import req_encoder_pkg::*;
#(
  parameter bit PRIO_HIGH = 1'b1
) (
  input  logic [REQ_W-1:0]  req,
  output logic [CODE_W-1:0] idx_c,
  output logic              any_c
);

  // Later loop iterations overwrite earlier ones, so scan order sets the winner.
  always_comb begin
    idx_c = '0;
    any_c = |req;
    if (PRIO_HIGH) begin
      for (int i = 0; i < int'(REQ_W); i++) begin
        if (req[i]) idx_c = CODE_W'(i);
      end
    end else begin
      for (int i = int'(REQ_W) - 1; i >= 0; i--) begin
        if (req[i]) idx_c = CODE_W'(i);
      end
    end
  end

endmodule

// File: rtl/req_encoder.sv
// Accumulates request lines into a pending set and issues one binary code per
// accepted handshake, highest priority first.
module req_encoder
  import req_encoder_pkg::*;
#(
  parameter bit PRIO_HIGH = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [REQ_W-1:0]  D,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [CODE_W-1:0] out_code,
  output logic [REQ_W-1:0]  pend,
  output logic [CNT_W-1:0]  pend_cnt
);

  logic [0:0]        state_q, state_d;
  logic [CODE_W-1:0] code_q,  code_d;
  logic [REQ_W-1:0]  pend_q,  pend_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;

  logic [CODE_W-1:0] pick_idx_c;
  logic              pick_any_c;
  logic              load_c;

  prio_pick8 #(.PRIO_HIGH(PRIO_HIGH)) u_pick (
    .req   (pend_q),
    .idx_c (pick_idx_c),
    .any_c (pick_any_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      code_q  <= '0;
      pend_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture is applied after the clear so a same-edge re-request survives.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    pend_d  = pend_q;
    load_c  = (state_q == ST_IDLE) || out_ready;
    if (load_c) begin
      if (pick_any_c) begin
        state_d            = ST_HOLD;
        code_d             = pick_idx_c;
        pend_d[pick_idx_c] = 1'b0;
      end else begin
        state_d = ST_IDLE;
      end
    end
    if (en) pend_d = pend_d | D;
    cnt_d = popcount(pend_d);
  end

  assign out_valid = (state_q == ST_HOLD);
  assign out_code  = code_q;
  assign pend      = pend_q;
  assign pend_cnt  = cnt_q;

endmodule

// File: tb/tb_req_encoder.sv
// Directed and randomized checks of req_encoder (both priority directions)
// against a per-line pending-set model.
module tb_req_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] d;
  logic       rdy;

  logic       v0, v1;
  logic [2:0] c0, c1;
  logic [7:0] p0, p1;
  logic [3:0] n0, n1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit p[8];
    bit valid;
    int code;
  } model_t;

  model_t m0, m1;

  always #5 clk = ~clk;

  req_encoder #(.PRIO_HIGH(1'b1)) dut_hi (
    .clk(clk), .rst_n(rst_n), .en(en), .D(d), .out_ready(rdy),
    .out_valid(v0), .out_code(c0), .pend(p0), .pend_cnt(n0)
  );

  req_encoder #(.PRIO_HIGH(1'b0)) dut_lo (
    .clk(clk), .rst_n(rst_n), .en(en), .D(d), .out_ready(rdy),
    .out_valid(v1), .out_code(c1), .pend(p1), .pend_cnt(n1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic model_t model_reset();
    model_t m;
    for (int i = 0; i < 8; i++) m.p[i] = 1'b0;
    m.valid = 1'b0;
    m.code  = 0;
    return m;
  endfunction

  // A served line is removed only if it was pending before the edge; new
  // requests seen on the same edge are added afterwards.
  function automatic model_t model_step(input model_t m, input bit hi,
                                        input bit e, input logic [7:0] dv, input bit r);
    model_t n;
    int     win;
    n   = m;
    win = -1;
    if (!m.valid || r) begin
      for (int k = 0; k < 8; k++) begin
        int line;
        line = hi ? 7 - k : k;
        if (win < 0 && m.p[line]) win = line;
      end
      if (win >= 0) begin
        n.p[win] = 1'b0;
        n.valid  = 1'b1;
        n.code   = win;
      end else begin
        n.valid = 1'b0;
      end
    end
    if (e) for (int i = 0; i < 8; i++) if (dv[i]) n.p[i] = 1'b1;
    return n;
  endfunction

  function automatic logic [7:0] pend_vec(input model_t m);
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = m.p[i];
    return v;
  endfunction

  function automatic int pend_count(input model_t m);
    int s;
    s = 0;
    for (int i = 0; i < 8; i++) s += int'(m.p[i]);
    return s;
  endfunction

  task automatic compare_all();
    check("hi_valid", 32'(v0), 32'(m0.valid));
    check("hi_code",  32'(c0), 32'(m0.code));
    check("hi_pend",  32'(p0), 32'(pend_vec(m0)));
    check("hi_cnt",   32'(n0), 32'(pend_count(m0)));
    check("lo_valid", 32'(v1), 32'(m1.valid));
    check("lo_code",  32'(c1), 32'(m1.code));
    check("lo_pend",  32'(p1), 32'(pend_vec(m1)));
    check("lo_cnt",   32'(n1), 32'(pend_count(m1)));
  endtask

  task automatic tick();
    @(posedge clk);
    m0 = model_step(m0, 1'b1, en, d, rdy);
    m1 = model_step(m1, 1'b0, en, d, rdy);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0; d = '0; rdy = 1'b0;
    #12;
    m0 = model_reset();
    m1 = model_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    m0 = model_reset();
    m1 = model_reset();
    do_reset();

    // Two requests drained back to back.
    en = 1'b1; d = 8'h28; rdy = 1'b1;
    tick();
    en = 1'b0; d = '0;
    tick(); check("b2b_first",  32'(c0), 32'd5); check("b2b_v1", 32'(v0), 32'd1);
    tick(); check("b2b_second", 32'(c0), 32'd3); check("b2b_v2", 32'(v0), 32'd1);
    tick(); check("b2b_idle",   32'(v0), 32'd0); check("b2b_pend", 32'(p0), 32'd0);

    // Capture disabled.
    en = 1'b0; d = 8'hFF;
    repeat (5) begin
      tick();
      check("en0_pend", 32'(p0), 32'd0);
      check("en0_valid", 32'(v0), 32'd0);
    end

    // Stall with out_ready low, then release.
    en = 1'b1; d = 8'h81; rdy = 1'b0;
    tick();
    en = 1'b0; d = '0;
    repeat (4) begin
      tick();
      check("stall_code", 32'(c0), 32'd7);
      check("stall_pend", 32'(p0), 32'h01);
      check("stall_cnt",  32'(n0), 32'd1);
    end
    rdy = 1'b1;
    tick(); check("stall_release", 32'(c0), 32'd0);
    tick();

    // Re-request of line 2 while it is being served.
    en = 1'b1; d = 8'h04; rdy = 1'b0;
    tick();
    en = 1'b0; d = '0;
    tick(); check("rr_hold_code", 32'(c0), 32'd2);
    en = 1'b1; d = 8'h04; rdy = 1'b1;
    tick(); check("rr_pend", 32'(p0), 32'h04);
    en = 1'b0; d = '0;
    tick(); check("rr_again_code", 32'(c0), 32'd2); check("rr_again_v", 32'(v0), 32'd1);
    tick();

    // Set and clear of the same line on one edge.
    en = 1'b1; d = 8'h0C; rdy = 1'b0;
    tick();
    en = 1'b0; d = '0;
    tick(); check("sc_hold", 32'(c0), 32'd3);
    en = 1'b1; d = 8'h04; rdy = 1'b1;
    tick(); check("sc_code", 32'(c0), 32'd2); check("sc_pend", 32'(p0), 32'h04);
    en = 1'b0; d = '0;
    tick(); check("sc_reserve", 32'(c0), 32'd2); check("sc_empty", 32'(p0), 32'd0);
    tick();

    // Low-first priority ordering.
    do_reset();
    en = 1'b1; d = 8'hC1; rdy = 1'b1;
    tick();
    en = 1'b0; d = '0;
    tick(); check("lo_first",  32'(c1), 32'd0);
    tick(); check("lo_second", 32'(c1), 32'd6);
    tick(); check("lo_third",  32'(c1), 32'd7);
    tick(); check("lo_done",   32'(v1), 32'd0);

    // Asynchronous reset in the middle of a HOLD.
    en = 1'b1; d = 8'hF0; rdy = 1'b0;
    tick();
    tick(); check("ar_pre_pend", 32'(p0), 32'hF0); check("ar_pre_v", 32'(v0), 32'd1);
    en = 1'b0; d = '0;
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(v0), 32'd0);
    check("ar_pend",  32'(p0), 32'd0);
    check("ar_cnt",   32'(n0), 32'd0);
    check("ar_code",  32'(c0), 32'd0);
    m0 = model_reset();
    m1 = model_reset();
    #2 rst_n = 1'b1;

    // Randomized traffic with occasional mid-cycle resets.
    for (int cyc = 0; cyc < 600; cyc++) begin
      en  = ($urandom_range(0, 3) != 0);
      d   = 8'($urandom) & 8'($urandom);
      rdy = ($urandom_range(0, 2) != 0);
      tick();
      if ($urandom_range(0, 99) == 0) begin
        #2 rst_n = 1'b0;
        m0 = model_reset();
        m1 = model_reset();
        #1 compare_all();
        #2 rst_n = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
